// File: rtl/spi_mcu_tx.sv
// SPI slave transmitter running on the system clock: SCK/CS are oversampled,
// outgoing words are queued in a small FIFO and shifted out over back-to-back frames.
module spi_mcu_tx #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mcu_sck,
    input  logic                         mcu_cs_n,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         data_valid,
    output logic                         data_ready,
    input  logic                         clear_underrun,
    output logic                         mcu_sdo,
    output logic                         tx_done,
    output logic                         underrun,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int   AW       = $clog2(DEPTH);
    localparam int   LW       = $clog2(DEPTH+1);
    localparam int   CW       = $clog2(WIDTH);
    localparam logic IDLE_SCK = (CPOL != 0);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                    state_q, state_d;
    logic [2:0]                sck_sync_q, sck_sync_d;
    logic [2:0]                cs_sync_q, cs_sync_d;
    logic [CW-1:0]             bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]          shreg_q, shreg_d;
    logic                      pend_q, pend_d;
    logic                      tx_done_q, tx_done_d;
    logic                      underrun_q, underrun_d;
    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]             level_q, level_d;

    logic sck_lead, sck_trail, sample_e, drive_e, cs_fall, cs_rise;
    logic load, pop, push, underrun_set;

    // Bit [1] is the synchronised level, bit [2] the previous one for edge detection.
    assign sck_lead  = (sck_sync_q[2] == IDLE_SCK) && (sck_sync_q[1] != IDLE_SCK);
    assign sck_trail = (sck_sync_q[2] != IDLE_SCK) && (sck_sync_q[1] == IDLE_SCK);
    assign sample_e  = (CPHA != 0) ? sck_trail : sck_lead;
    assign drive_e   = (CPHA != 0) ? sck_lead : sck_trail;
    assign cs_fall   = cs_sync_q[2] && !cs_sync_q[1];
    assign cs_rise   = !cs_sync_q[2] && cs_sync_q[1];

    assign data_ready = (level_q != LW'(DEPTH));
    assign push       = data_valid && data_ready;
    assign mcu_sdo    = (state_q == ACTIVE) &&
                        ((MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign tx_done    = tx_done_q;
    assign underrun   = underrun_q;
    assign level      = level_q;

    always_comb begin
        sck_sync_d   = {sck_sync_q[1:0], mcu_sck};
        cs_sync_d    = {cs_sync_q[1:0], mcu_cs_n};
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        pend_d       = pend_q;
        tx_done_d    = 1'b0;
        underrun_set = 1'b0;
        load         = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                    pend_d    = 1'b0;
                    if (CPHA == 0) load = 1'b1;
                end
            end
            default: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                    pend_d    = 1'b0;
                end else if (sample_e) begin
                    if (bit_cnt_q == CW'(WIDTH-1)) begin
                        bit_cnt_d = '0;
                        tx_done_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    // An empty-FIFO word only counts as an underrun once the MCU
                    // actually clocks it; the speculative load after a frame's
                    // last word is harmless if CS rises first.
                    if (pend_q) begin
                        underrun_set = 1'b1;
                        pend_d       = 1'b0;
                    end
                end else if (drive_e) begin
                    if (bit_cnt_q == '0) load = 1'b1;
                    else shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
                end
            end
        endcase

        pop = load && (level_q != '0);
        if (load) begin
            shreg_d = pop ? mem_q[rd_ptr_q] : '0;
            pend_d  = !pop;
        end

        underrun_d = underrun_set ? 1'b1 : (clear_underrun ? 1'b0 : underrun_q);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync_q <= {3{IDLE_SCK}};
            cs_sync_q  <= 3'b111;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            pend_q     <= 1'b0;
            tx_done_q  <= 1'b0;
            underrun_q <= 1'b0;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            sck_sync_q <= sck_sync_d;
            cs_sync_q  <= cs_sync_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            pend_q     <= pend_d;
            tx_done_q  <= tx_done_d;
            underrun_q <= underrun_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end
endmodule

// File: tb/tb_spi_mcu_tx.sv
// Scoreboard bench: three spi_mcu_tx variants share one MCU SCK/CS; a frame-level
// model predicts the words each MCU sees, a monitor checks them on tx_done.
module tb_spi_mcu_tx;
    logic clk, reset, sck, sckb, cs_n;
    logic [15:0] d0;
    logic [7:0]  d1;
    logic [23:0] d2;
    logic [2:0]  v, r, cl, so, td, ur;
    logic [2:0]  lv0, lv1, lv2;

    int n_chk = 0;
    int n_fail = 0;

    logic [23:0] mf0[$], mf1[$], mf2[$];
    logic [23:0] ex0[$], ex1[$], ex2[$];
    logic [23:0] cp0[$], cp1[$], cp2[$];
    bit ur_m[3];

    logic [23:0] sh0, sh1, sh2;
    int c0, c1, c2;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    assign sckb = ~sck;

    spi_mcu_tx #(.WIDTH(16)) u0 (
        .clk(clk), .reset(reset), .mcu_sck(sck), .mcu_cs_n(cs_n),
        .data_in(d0), .data_valid(v[0]), .data_ready(r[0]), .clear_underrun(cl[0]),
        .mcu_sdo(so[0]), .tx_done(td[0]), .underrun(ur[0]), .level(lv0));
    spi_mcu_tx #(.WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) u1 (
        .clk(clk), .reset(reset), .mcu_sck(sckb), .mcu_cs_n(cs_n),
        .data_in(d1), .data_valid(v[1]), .data_ready(r[1]), .clear_underrun(cl[1]),
        .mcu_sdo(so[1]), .tx_done(td[1]), .underrun(ur[1]), .level(lv1));
    spi_mcu_tx #(.WIDTH(24)) u2 (
        .clk(clk), .reset(reset), .mcu_sck(sck), .mcu_cs_n(cs_n),
        .data_in(d2), .data_valid(v[2]), .data_ready(r[2]), .clear_underrun(cl[2]),
        .mcu_sdo(so[2]), .tx_done(td[2]), .underrun(ur[2]), .level(lv2));

    function automatic int wid(int i);
        case (i) 0: return 16; 1: return 8; default: return 24; endcase
    endfunction
    function automatic int cpha(int i);
        return (i == 1) ? 1 : 0;
    endfunction
    function automatic int mf_size(int i);
        case (i) 0: return mf0.size(); 1: return mf1.size(); default: return mf2.size(); endcase
    endfunction
    function automatic int ex_size(int i);
        case (i) 0: return ex0.size(); 1: return ex1.size(); default: return ex2.size(); endcase
    endfunction
    function automatic logic [2:0] lvl(int i);
        case (i) 0: return lv0; 1: return lv1; default: return lv2; endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mf_push(input int i, input logic [23:0] w);
        case (i) 0: mf0.push_back(w); 1: mf1.push_back(w); default: mf2.push_back(w); endcase
    endtask
    task automatic mf_pop(input int i, output logic [23:0] w, output bit empty);
        empty = (mf_size(i) == 0);
        w = '0;
        if (!empty)
            case (i) 0: w = mf0.pop_front(); 1: w = mf1.pop_front(); default: w = mf2.pop_front(); endcase
    endtask
    task automatic ex_push(input int i, input logic [23:0] w);
        case (i) 0: ex0.push_back(w); 1: ex1.push_back(w); default: ex2.push_back(w); endcase
    endtask

    // Frame model: every word the MCU clocks comes from the FIFO in order (zeros
    // when empty). CPHA=0 loads at CS fall and after every completed word;
    // CPHA=1 loads at the first edge of each word. Partial words are lost.
    task automatic model_frame(input int i, input int n);
        int w, loads, bits;
        logic [23:0] word;
        bit empty;
        w = wid(i);
        loads = (cpha(i) != 0) ? (n + w - 1) / w : n / w + 1;
        for (int k = 0; k < loads; k++) begin
            bits = n - k * w;
            if (bits > w) bits = w;
            mf_pop(i, word, empty);
            if (empty && bits > 0) ur_m[i] = 1'b1;
            if (bits == w) ex_push(i, word);
        end
    endtask

    task automatic mon_pop(input int i);
        logic [31:0] e, c;
        e = 32'hBAD0_0000;
        c = 32'hDEAD_0000;
        case (i)
            0: begin if (ex0.size() > 0) e = {8'h0, ex0.pop_front()};
                     if (cp0.size() > 0) c = {8'h0, cp0.pop_front()}; end
            1: begin if (ex1.size() > 0) e = {8'h0, ex1.pop_front()};
                     if (cp1.size() > 0) c = {8'h0, cp1.pop_front()}; end
            default: begin if (ex2.size() > 0) e = {8'h0, ex2.pop_front()};
                     if (cp2.size() > 0) c = {8'h0, cp2.pop_front()}; end
        endcase
        check($sformatf("u%0d_word", i), c, e);
    endtask

    // MCU receivers: u0/u2 sample on SCK rise MSB first, u1 on its own rise (SCK fall) LSB first.
    always @(posedge sck or posedge cs_n) begin
        if (cs_n) c0 <= 0;
        else begin
            sh0 <= {sh0[22:0], so[0]};
            if (c0 == 15) begin cp0.push_back({8'h0, sh0[14:0], so[0]}); c0 <= 0; end
            else c0 <= c0 + 1;
        end
    end
    always @(negedge sck or posedge cs_n) begin
        if (cs_n) c1 <= 0;
        else begin
            sh1 <= {16'h0, so[1], sh1[7:1]};
            if (c1 == 7) begin cp1.push_back({16'h0, so[1], sh1[7:1]}); c1 <= 0; end
            else c1 <= c1 + 1;
        end
    end
    always @(posedge sck or posedge cs_n) begin
        if (cs_n) c2 <= 0;
        else begin
            sh2 <= {sh2[22:0], so[2]};
            if (c2 == 23) begin cp2.push_back({sh2[22:0], so[2]}); c2 <= 0; end
            else c2 <= c2 + 1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            if (td[i]) mon_pop(i);
    end

    task automatic push(input int i, input logic [23:0] w);
        bit acc;
        logic [23:0] m;
        m = 24'((32'h1 << wid(i)) - 1);
        @(negedge clk);
        acc = (mf_size(i) < 4);
        case (i) 0: d0 = w[15:0]; 1: d1 = w[7:0]; default: d2 = w; endcase
        v[i] = 1'b1;
        check($sformatf("u%0d_ready", i), {31'h0, r[i]}, {31'h0, acc});
        check($sformatf("u%0d_level_pre", i), {29'h0, lvl(i)}, mf_size(i));
        @(negedge clk);
        v[i] = 1'b0;
        if (acc) mf_push(i, w & m);
    endtask

    task automatic clear_all();
        @(negedge clk) cl = 3'b111;
        @(negedge clk) cl = 3'b000;
        for (int i = 0; i < 3; i++) ur_m[i] = 1'b0;
    endtask

    task automatic end_checks();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d_sdo_idle", i), {31'h0, so[i]}, 32'h0);
            check($sformatf("u%0d_words_pending", i), ex_size(i), 32'h0);
            check($sformatf("u%0d_underrun", i), {31'h0, ur[i]}, {31'h0, ur_m[i]});
            check($sformatf("u%0d_level", i), {29'h0, lvl(i)}, mf_size(i));
        end
    endtask

    task automatic sck_pulses(input int n);
        repeat (n) begin
            sck = 1'b1; repeat (6) @(negedge clk);
            sck = 1'b0; repeat (6) @(negedge clk);
        end
    endtask

    task automatic frame(input int n);
        for (int i = 0; i < 3; i++) model_frame(i, n);
        @(negedge clk) cs_n = 1'b0;
        repeat (6) @(negedge clk);
        sck_pulses(n);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        end_checks();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; sck = 1'b0; cs_n = 1'b1;
        v = '0; cl = '0; d0 = '0; d1 = '0; d2 = '0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d_rst_sdo", i), {31'h0, so[i]}, 32'h0);
            check($sformatf("u%0d_rst_ready", i), {31'h0, r[i]}, 32'h1);
            check($sformatf("u%0d_rst_level", i), {29'h0, lvl(i)}, 32'h0);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in the middle of a frame (bit 7 of u0's word).
        push(0, 24'h00AAAA);
        push(0, 24'h005555);
        @(negedge clk) cs_n = 1'b0;
        repeat (6) @(negedge clk);
        sck_pulses(7);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d_midrst_sdo", i), {31'h0, so[i]}, 32'h0);
            check($sformatf("u%0d_midrst_done", i), {31'h0, td[i]}, 32'h0);
            check($sformatf("u%0d_midrst_ur", i), {31'h0, ur[i]}, 32'h0);
            check($sformatf("u%0d_midrst_ready", i), {31'h0, r[i]}, 32'h1);
            check($sformatf("u%0d_midrst_level", i), {29'h0, lvl(i)}, 32'h0);
            ur_m[i] = 1'b0;
        end
        mf0.delete(); mf1.delete(); mf2.delete();
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("u0_level_after_rst", {29'h0, lv0}, 32'h0);

        // Single word in every mode.
        push(0, 24'h00A5C3);
        push(1, 24'h000001);
        push(1, 24'h000080);
        frame(16);
        clear_all();
        check("u2_ur_cleared", {31'h0, ur[2]}, 32'h0);

        // Continuous frames, plus the 24-bit word.
        push(0, 24'h001234); push(0, 24'h00BEEF); push(0, 24'h000F0F);
        push(2, 24'hC0FFEE);
        for (int k = 0; k < 6; k++) push(1, 24'($urandom()));
        frame(48);
        clear_all();

        // Underrun is sticky through a good word until cleared.
        frame(16);
        push(0, 24'h00600D);
        frame(16);
        clear_all();
        check("u0_ur_cleared", {31'h0, ur[0]}, 32'h0);

        // Abort after 5 bits, next frame returns the second word.
        push(0, 24'h00FFFF);
        push(0, 24'h008001);
        frame(5);
        frame(16);
        clear_all();

        // Fill to DEPTH; the fifth push is refused.
        for (int k = 0; k < 5; k++) push(0, 24'(32'h1000 + k));
        check("u0_full_ready", {31'h0, r[0]}, 32'h0);
        check("u0_full_level", {29'h0, lv0}, 32'h4);
        frame(64);
        clear_all();

        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < 3; i++) begin
                int k;
                k = $urandom_range(0, 5);
                repeat (k) push(i, 24'($urandom()));
            end
            if ($urandom_range(0, 3) == 0) clear_all();
            frame($urandom_range(0, 60));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_mcu_tx.md
# spi_mcu_tx

Parametrised SPI slave transmitter that returns FPGA results to the MCU. Unlike earlier transmit paths, which clocked the shift register directly from the MCU SCK, this block runs entirely on the FPGA system clock. It oversamples MCU SCK and CS through synchronisers and buffers outgoing words in a small FIFO. Words are written by FPGA-side logic through a valid/ready handshake and shifted out over successive SPI frames while CS stays low.

## Interface
Parameters:
- WIDTH, 16: bits per SPI word (≥2).
- DEPTH, 4: FIFO entries; power of 2, ≥2.
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = MCU samples on leading edge, 1 = MCU samples on trailing edge.
- MSB_FIRST, 1: 1 = shift MSB first, 0 = LSB first.

Ports:
- clk  in  1  system clock; the block's only clock.
- reset  in  1  asynchronous, active-high reset.
- mcu_sck  in  1  SPI clock from MCU, asynchronous to clk.
- mcu_cs_n  in  1  active-low chip select from MCU, asynchronous to clk.
- data_in  in  WIDTH  word to queue.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  FIFO not full; a word is written when data_valid && data_ready.
- clear_underrun  in  1  clears the underrun flag.
- mcu_sdo  out  1  serial data to MCU.
- tx_done  out  1  one-cycle pulse when a full word has been sampled by the MCU.
- underrun  out  1  sticky flag: a word was needed but the FIFO was empty.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- Synchronisers: mcu_sck and mcu_cs_n each pass through 2 flops. Reset values are CPOL and 1 respectively. A third flop feeds edge detection.
- Edge definitions: leading = synced SCK leaves CPOL; trailing = returns to CPOL.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1.
  - Drive edge = the other edge.
- FSM states:
  - IDLE → ACTIVE on synced CS falling edge.
  - ACTIVE → IDLE on synced CS rising edge, from any bit position.
- Word load, which pops the FIFO into the shift register and drives the first bit:
  - CPHA=0: at CS fall, and at every drive edge where bit_cnt==0 after a completed word.
  - CPHA=1: at every drive edge where bit_cnt==0.
- Subsequent drive edges shift the register by one and present the next bit, in MSB_FIRST order.
- bit_cnt increments on each sample edge. At WIDTH-1 it wraps to 0 and tx_done pulses; transfers are continuous while CS stays low.
- Load with an empty FIFO: shift all-zeros for that word, set underrun, leave the FIFO unchanged.
- CS rise mid-word:
  - abort the transfer;
  - discard the partial word (it is not re-queued);
  - clear bit_cnt;
  - drive mcu_sdo to 0;
  - no tx_done pulse.
- Drive edges with CS high are ignored.
- mcu_sdo = 0 whenever in IDLE.
- FIFO:
  - data_ready = (level != DEPTH).
  - A push and a pop in the same cycle are both performed; level is unchanged.
  - A push into an empty FIFO in the same cycle as a load is not visible to that load: underrun is set, and the pushed word is kept for the next load.
- underrun: set has priority over clear_underrun in the same cycle; cleared otherwise when clear_underrun=1.

## Timing
- Reset values: mcu_sdo=0, tx_done=0, underrun=0, level=0, data_ready=1, FSM=IDLE, bit_cnt=0, FIFO empty.
- Each SCK half-period must be ≥4 clk cycles; CS setup to first SCK edge ≥4 clk cycles.
- mcu_sdo updates exactly 3 clk cycles after the raw SCK drive edge or raw CS fall: 2 synchroniser cycles plus 1 registered-edge cycle.
- tx_done asserts 3 clk cycles after the raw sample edge of the last bit.
- level and data_ready update the cycle after a push or pop.

## Test plan
- Reset mid-transfer (CS low, bit 7 of 16) → all outputs at reset values the same cycle reset asserts; FIFO empty after release.
- Mode 0 single word: push 0xA5C3, CS low, 16 SCK pulses → MCU samples 1010_0101_1100_0011 MSB first; one tx_done; level 1→0.
- Continuous frames:
  - push 0x1234, 0xBEEF, 0x0F0F; hold CS low for 48 SCK → three words in order, three tx_done pulses, underrun=0;
  - fill to DEPTH=4 → data_ready=0; a 5th push is not accepted.
- Underrun: FIFO empty, CS low, 16 SCK → MCU reads 0x0000 and underrun=1; underrun stays 1 through the next good word until clear_underrun is pulsed.
- Abort: push 0xFFFF, 0x8001; CS rises after 5 SCK → no tx_done, mcu_sdo=0; next frame returns 0x8001.
- Parameter sweep:
  - CPOL=1, CPHA=1, MSB_FIRST=0, WIDTH=8: push 0x01 → MCU sampling on rising edges reads 1,0,0,0,0,0,0,0.
  - WIDTH=24: push 0xC0FFEE → read back exactly.
